// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package ysyx_23060332_ifu_pkg;

    localparam int          INST_BUS      = 32;
    localparam int          INST_ADDR_BUS = 32;
    localparam logic [31:0] PC_RST        = 32'h8000_0000;
    localparam logic [31:0] INST_NOP      = 32'h0000_0013;
    localparam logic        VALID         = 1'b1;
    localparam logic        INVALID       = 1'b0;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2,
        IFU_OUT  = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ysyx_23060332_ifu_pc.sv
// PC register with deferred-redirect capture for fetches already in flight.
module ysyx_23060332_ifu_pc
    import ysyx_23060332_ifu_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = PC_RST
) (
    input  logic            clk,
    input  logic            rst,
    input  ifu_state_e      state,
    input  logic            rsp_valid,
    input  logic            inst_fire,
    input  logic            jump_flag,
    input  logic [XLEN-1:0] jump_addr,
    output logic [XLEN-1:0] pc,
    output logic            redir_pend
);

    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] jump_tgt;
    logic [XLEN-1:0] pc_nxt;
    logic            pend_nxt;
    logic [XLEN-1:0] redir_pc_nxt;

    assign jump_tgt = {jump_addr[XLEN-1:2], 2'b00};

    always_comb begin
        pc_nxt       = pc;
        pend_nxt     = redir_pend;
        redir_pc_nxt = redir_pc;
        case (state)
            IFU_REQ: begin
                if (jump_flag) begin
                    pend_nxt     = 1'b1;
                    redir_pc_nxt = jump_tgt;
                end
            end
            IFU_WAIT: begin
                // A response arriving with a live or pending redirect is dropped.
                if (rsp_valid) begin
                    pend_nxt = 1'b0;
                    if (jump_flag)
                        pc_nxt = jump_tgt;
                    else if (redir_pend)
                        pc_nxt = redir_pc;
                end else if (jump_flag) begin
                    pend_nxt     = 1'b1;
                    redir_pc_nxt = jump_tgt;
                end
            end
            IFU_OUT: begin
                if (jump_flag)
                    pc_nxt = jump_tgt;
                else if (inst_fire)
                    pc_nxt = pc + XLEN'(4);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= XLEN'(RESET_PC);
            redir_pend <= 1'b0;
            redir_pc   <= '0;
        end else begin
            pc         <= pc_nxt;
            redir_pend <= pend_nxt;
            redir_pc   <= redir_pc_nxt;
        end
    end

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: REQ/WAIT/OUT fetch loop feeding decode, with jump squash.
module ysyx_23060332_ifu
    import ysyx_23060332_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RST,
    parameter int          XLEN     = INST_ADDR_BUS
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [XLEN-1:0] req_addr_o,
    input  logic            rsp_valid_i,
    output logic            rsp_ready_o,
    input  logic [XLEN-1:0] rsp_data_i,
    input  logic            rsp_err_i,
    input  logic            jump_flag_i,
    input  logic [XLEN-1:0] jump_addr_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o,
    output logic            inst_err_o
);

    ifu_state_e      state;
    ifu_state_e      state_nxt;
    logic [XLEN-1:0] pc;
    logic            redir_pend;
    logic            inst_fire;
    logic            rsp_keep;

    assign inst_fire = (state == IFU_OUT) && inst_ready_i;
    assign rsp_keep  = (state == IFU_WAIT) && rsp_valid_i && !redir_pend && !jump_flag_i;

    ysyx_23060332_ifu_pc #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .rsp_valid  (rsp_valid_i),
        .inst_fire  (inst_fire),
        .jump_flag  (jump_flag_i),
        .jump_addr  (jump_addr_i),
        .pc         (pc),
        .redir_pend (redir_pend)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IFU_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IFU_IDLE: state_nxt = IFU_REQ;
            IFU_REQ:  if (req_ready_i) state_nxt = IFU_WAIT;
            IFU_WAIT: begin
                if (rsp_valid_i)
                    state_nxt = (redir_pend || jump_flag_i) ? IFU_REQ : IFU_OUT;
            end
            IFU_OUT:  if (inst_ready_i || jump_flag_i) state_nxt = IFU_REQ;
            default:  state_nxt = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_o      <= '0;
            inst_addr_o <= '0;
            inst_err_o  <= 1'b0;
        end else if (rsp_keep) begin
            inst_o      <= rsp_data_i;
            inst_addr_o <= pc;
            inst_err_o  <= rsp_err_i;
        end
    end

    // Handshake outputs decode from the registered state only.
    assign req_valid_o  = (state == IFU_REQ);
    assign rsp_ready_o  = (state == IFU_WAIT);
    assign inst_valid_o = (state == IFU_OUT);
    assign req_addr_o   = pc;

endmodule
